s_axis_frame_buf: RTL and testbench
===================================

Name: s_axis_frame_buf

Overview:
AXI4-Stream slave that receives one frame from the DMA MM2S channel into block RAM. Once the frame is closed, it replays the frame as a gap-free in_data/in_valid/in_last-style stream (out_data/out_valid/out_last) toward the processing/TX stage.
Frames are bounded to FRAME_LEN words; short and over-long frames are flagged. Input and output never overlap: the block is a single-frame store-and-forward buffer.

Parameters:
DATA_W, 32, stream data width (tstrb width = DATA_W/8)
DEPTH_LOG2, 10, log2 of buffer depth in words
FRAME_LEN, 800, maximum/nominal frame length in words; must satisfy 1 <= FRAME_LEN <= 2**DEPTH_LOG2

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
s_axis_tdata  in  DATA_W  input beat data
s_axis_tstrb  in  DATA_W/8  byte strobes
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  last beat of frame
s_axis_tready  out  1  input ready
out_data  out  DATA_W  replayed word
out_valid  out  1  out_data valid; no backpressure
out_last  out  1  with final replayed word
frame_len  out  DEPTH_LOG2+1  stored length of the most recent frame
err_short  out  1  1-cycle pulse: tlast before FRAME_LEN beats
err_long  out  1  1-cycle pulse: FRAME_LEN beats without tlast

Behaviour:
- Reset: state=IDLE, wr_ptr=rd_ptr=0, all outputs 0. frame_len=0. Memory contents are not reset.
- Accept = s_axis_tvalid && s_axis_tready. s_axis_tready=1 only in RECV and FLUSH (decoded from registered state).
- IDLE: goes to RECV unconditionally on the next cycle, so tready rises 1 cycle after reset release.
- RECV, on accept:
  - Write mem[wr_ptr] and increment wr_ptr.
  - Written word: byte i = tdata byte i if tstrb[i] is set, else 0x00.
  - Beat count n = wr_ptr+1.
- RECV exits:
  - tlast && n<FRAME_LEN: pulse err_short in the next cycle, frame_len<=n, go to DRAIN.
  - tlast && n==FRAME_LEN: frame_len<=FRAME_LEN, go to DRAIN; no error.
  - !tlast && n==FRAME_LEN: pulse err_long in the next cycle, frame_len<=FRAME_LEN, go to FLUSH.
- FLUSH: accepted beats are discarded (not written); accepting a beat with tlast goes to DRAIN.
- DRAIN:
  - tready=0. Issue one read per cycle at rd_ptr=0..frame_len-1. Block RAM read latency is 1.
  - out_data/out_valid are registered from the read: out_valid=1 exactly one cycle after each read.
  - out_last=1 with the word read at frame_len-1.
  - After the last read issue: rd_ptr=0, wr_ptr=0, state=RECV.
- Timing: if the closing beat is accepted at cycle T, then out_valid is high for T+2..T+frame_len+1 contiguously, out_last is at T+frame_len+1, and tready returns at T+frame_len+1.
- A write followed by a read of the same address on the next cycle returns the new data (frame_len=1 case).
- Zero-length frames are impossible: tlast on the first beat gives frame_len=1.
- out_data holds its last value when out_valid=0.
- Reset mid-frame or mid-DRAIN: the partial frame is dropped; all outputs are 0 at the next edge; the block restarts via IDLE.
- Pointer widths are DEPTH_LOG2; counts and frame_len are DEPTH_LOG2+1, so FRAME_LEN = 2**DEPTH_LOG2 is representable.

Test Plan:
1. 800-beat ramp 0..799, tvalid continuous, tlast on beat 800 -> tready low from the next cycle; out_data 0..799 on 800 contiguous cycles; out_last with 799; frame_len=800; no error pulses; tready high again on the out_last cycle.
2. 5-beat frame 10..14, tlast on beat 5 -> err_short one pulse; frame_len=5; outputs 10..14; out_last on 14.
3. 803-beat frame, tlast on beat 803 -> err_long one pulse after beat 800; beats 801..803 accepted and dropped; 800 outputs ending with beat 800's data; frame_len=800.
4. Single beat 0xAABBCCDD, tstrb=4'b0101, tlast -> frame_len=1; one output 0x00BB00DD with out_valid and out_last together.
5. Frame from test 1 with random tvalid gaps (about 50%) -> output identical to test 1, contiguous; then a second frame back-to-back is received correctly.
6. rstn low for 1 cycle after 100 replayed words -> out_valid/out_last/tready 0 at the next edge; tready 0 for one cycle after release, then 1; a following 3-beat frame replays only its 3 words.

Source files
------------

// File: rtl/s_axis_frame_buf_if.sv
// AXI4-Stream slave-side bundle for the frame buffer input (tdata/tstrb/tvalid/tlast/tready).
interface s_axis_frame_buf_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  // Upstream (DMA MM2S) side drives the beat, sees ready.
  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  // Buffer side consumes the beat, drives ready.
  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/s_axis_frame_buf.sv
// Single-frame store-and-forward buffer: receives one AXI4-Stream frame into
// block RAM, then replays it as a gap-free out_data/out_valid/out_last stream.
// Receive and replay never overlap; over-long frames are truncated to FRAME_LEN.
module s_axis_frame_buf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned FRAME_LEN  = 800
) (
  input  logic                  clk,
  input  logic                  rstn,
  s_axis_frame_buf_if.slave     s_axis,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DEPTH_LOG2:0]   frame_len,
  output logic                  err_short,
  output logic                  err_long
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              tready_q;

  logic              accept_c;
  logic [CNT_W-1:0]  beat_cnt_c;
  logic [CNT_W-1:0]  rd_cnt_c;
  logic [DATA_W-1:0] wdata_c;
  logic              wr_en_c;
  logic              rd_en_c;
  logic              rd_last_c;
  logic              close_c;
  logic              short_c;
  logic              long_c;

  assign s_axis.tready = tready_q;
  assign accept_c      = s_axis.tvalid & tready_q;
  assign beat_cnt_c    = {1'b0, wr_ptr} + CNT_W'(1);
  assign rd_cnt_c      = {1'b0, rd_ptr} + CNT_W'(1);

  // Byte-mask the incoming beat: unstrobed bytes are stored as zero.
  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      wdata_c[8*i +: 8] = s_axis.tstrb[i] ? s_axis.tdata[8*i +: 8] : 8'h00;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Per-cycle datapath strobes decoded from the current state and handshake.
  always_comb begin
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    rd_last_c = 1'b0;
    close_c   = 1'b0;
    short_c   = 1'b0;
    long_c    = 1'b0;
    case (state)
      ST_RECV: begin
        if (accept_c) begin
          wr_en_c = 1'b1;
          if (beat_cnt_c == FRAME_LEN_C) begin
            close_c = 1'b1;
            long_c  = ~s_axis.tlast;
          end else if (s_axis.tlast) begin
            close_c = 1'b1;
            short_c = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        rd_en_c   = 1'b1;
        rd_last_c = (rd_cnt_c == frame_len);
      end
      default: begin
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        state_nx = ST_RECV;
      end
      ST_RECV: begin
        if (close_c) begin
          state_nx = long_c ? ST_FLUSH : ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (accept_c && s_axis.tlast) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rd_last_c) begin
          state_nx = ST_RECV;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Frame store; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (rstn && wr_en_c) begin
      mem[wr_ptr] <= wdata_c;
    end
  end

  // Pointers, registered replay stream, ready, length and error pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tready_q  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_len <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      tready_q  <= (state_nx == ST_RECV) || (state_nx == ST_FLUSH);
      err_short <= short_c;
      err_long  <= long_c;
      out_valid <= rd_en_c;
      out_last  <= rd_last_c;
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (close_c) begin
        frame_len <= beat_cnt_c;
      end
      if (rd_en_c) begin
        out_data <= mem[rd_ptr];
        if (rd_last_c) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_s_axis_frame_buf.sv
// Scoreboard bench for s_axis_frame_buf: stimulus pushes expected replay words,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_s_axis_frame_buf;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned FRAME_LEN  = 800;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  s_axis_frame_buf_if #(.DATA_W(DATA_W)) s_if ();

  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_last;
  logic [DEPTH_LOG2:0] frame_len;
  logic                err_short;
  logic                err_long;

  s_axis_frame_buf #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_axis   (s_if.slave),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .frame_len(frame_len),
    .err_short(err_short),
    .err_long (err_long)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          checks     = 0;
  int          errors     = 0;
  int          short_cnt  = 0;
  int          long_cnt   = 0;
  int          words_seen = 0;
  bit          in_frame   = 1'b0;
  logic [31:0] last_exp   = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per out_valid, checks contiguity and ready on out_last.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        in_frame = 1'b0;
      end else begin
        if (err_short) short_cnt++;
        if (err_long)  long_cnt++;
        if (in_frame) check("out_valid_contiguous", 32'(out_valid), 32'd1);
        if (out_valid) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=0x%0h required=none", out_data);
            in_frame = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", 32'(out_last), 32'(e.last));
            if (out_last) check("tready_on_out_last", 32'(s_if.tready), 32'd1);
            in_frame = !out_last;
          end
        end
      end
    end
  end

  // Present one beat at a negedge and hold it until accepted; returns at the next negedge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] st, input logic l);
    int guard = 0;
    s_if.tdata  = d;
    s_if.tstrb  = st;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("FAIL tready_timeout actual=0 required=1");
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Ramp frame base..base+nbeats-1, tlast on the final beat, optional random idle gaps.
  task automatic send_frame(input int nbeats, input logic [31:0] base, input bit gaps);
    exp_t e;
    short_cnt = 0;
    long_cnt  = 0;
    for (int k = 1; k <= nbeats; k++) begin
      if (k <= int'(FRAME_LEN)) begin
        e.data = base + 32'(k - 1);
        e.last = (k == nbeats) || (k == int'(FRAME_LEN));
        exp_q.push_back(e);
        if (e.last) last_exp = e.data;
      end
      if (gaps && ($urandom_range(0, 1) == 1)) @(negedge clk);
      send_beat(base + 32'(k - 1), 4'hF, k == nbeats);
      if (k == int'(FRAME_LEN) && nbeats > int'(FRAME_LEN))
        check("err_long_pulse", 32'(err_long), 32'd1);
      if (k == nbeats) begin
        check("tready_drop", 32'(s_if.tready), 32'd0);
        check("err_short_at_close", 32'(err_short), (nbeats < int'(FRAME_LEN)) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // Wait for the replay to finish, then check length, held data and error pulse counts.
  task automatic finish_frame(input int exp_len, input int exp_short, input int exp_long);
    int guard = 0;
    @(negedge clk);
    #1;
    while ((exp_q.size() != 0 || in_frame) && guard < 4000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 4000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    check("frame_len", 32'(frame_len), 32'(exp_len));
    check("out_data_hold", out_data, last_exp);
    check("out_valid_idle", 32'(out_valid), 32'd0);
    check("err_short_count", 32'(short_cnt), 32'(exp_short));
    check("err_long_count", 32'(long_cnt), 32'(exp_long));
  endtask

  initial begin
    exp_t e;
    int   base;
    int   guard;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_tready", 32'(s_if.tready), 32'd0);
    check("rst_err", 32'({err_short, err_long}), 32'd0);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("tready_after_release", 32'(s_if.tready), 32'd1);

    // 1: nominal 800-beat ramp
    send_frame(800, 32'h0, 1'b0);
    finish_frame(800, 0, 0);

    // 2: short frame 10..14
    send_frame(5, 32'd10, 1'b0);
    finish_frame(5, 1, 0);

    // 3: 803 beats, last three dropped
    send_frame(803, 32'h1000, 1'b0);
    finish_frame(800, 0, 1);

    // 4: single strobed beat
    short_cnt = 0;
    long_cnt  = 0;
    e.data = 32'h00BB_00DD;
    e.last = 1'b1;
    exp_q.push_back(e);
    last_exp = e.data;
    send_beat(32'hAABB_CCDD, 4'b0101, 1'b1);
    check("single_tready_drop", 32'(s_if.tready), 32'd0);
    check("single_err_short", 32'(err_short), 32'd1);
    finish_frame(1, 1, 0);

    // 5: gappy 800-beat ramp then a back-to-back short frame
    send_frame(800, 32'h0, 1'b1);
    send_frame(4, 32'h5000, 1'b0);
    finish_frame(4, 1, 0);

    // 6: reset after 100 replayed words, then a 3-beat frame
    base = words_seen;
    send_frame(800, 32'h2000, 1'b0);
    guard = 0;
    while (words_seen < base + 100 && guard < 5000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL replay_start_timeout actual=%0d required=%0d", words_seen - base, 100);
    end
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_tready", 32'(s_if.tready), 32'd0);
    check("midrst_frame_len", 32'(frame_len), 32'd0);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("midrst_tready_back", 32'(s_if.tready), 32'd1);
    send_frame(3, 32'h300, 1'b0);
    finish_frame(3, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
